// File: rtl/adder_pkg.sv
// Shared elaboration helpers for pipelined_adder: stage count, per-stage widths
// and the parameter legality rule.
package adder_pkg;

    function automatic bit params_ok(int width, int chunk);
        return (chunk >= 1) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

    function automatic int stages_of(int width, int chunk);
        return (chunk >= 1) ? (width / chunk) : 1;
    endfunction

    // Stage idx forwards its finished low sum bits plus both operands' pending upper bits.
    function automatic int stage_out_w(int width, int chunk, int idx);
        return 2 * width - chunk * (idx + 1);
    endfunction

    // The last stage keeps the carry into the MSB alongside its carry-out.
    function automatic int stage_flag_w(int width, int chunk, int idx);
        return (chunk * (idx + 1) == width) ? 2 : 1;
    endfunction

endpackage

// File: rtl/adder_stage.sv
// One pipeline stage: resolves a CHUNK-bit slice of the carry chain and holds the
// partial result with its own valid bit and ready/load logic.
module adder_stage
    import adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2,
    parameter int IDX   = 0
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic                                           src_valid,
    input  logic [2*WIDTH-CHUNK*IDX-1:0]                   src_data,
    input  logic                                           src_carry,
    input  logic                                           dst_ready,
    output logic                                           ready,
    output logic                                           valid,
    output logic [stage_out_w(WIDTH, CHUNK, IDX)-1:0]      data,
    output logic [stage_flag_w(WIDTH, CHUNK, IDX)-1:0]     flags
);

    localparam int LO     = CHUNK * IDX;
    localparam int UP     = WIDTH - LO;
    localparam int OUT_W  = stage_out_w(WIDTH, CHUNK, IDX);
    localparam int FLAG_W = stage_flag_w(WIDTH, CHUNK, IDX);

    // src_data layout: {rhs[WIDTH-1:LO], lhs[WIDTH-1:LO], sum[LO-1:0]}
    logic [CHUNK-1:0]  a;
    logic [CHUNK-1:0]  b;
    logic [CHUNK:0]    slice;
    logic [OUT_W-1:0]  data_d;
    logic [FLAG_W-1:0] flags_d;

    assign a     = src_data[LO +: CHUNK];
    assign b     = src_data[LO+UP +: CHUNK];
    assign slice = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, src_carry};
    assign ready = !valid || dst_ready;

    always_comb begin
        data_d = '0;
        for (int i = 0; i < LO; i++)
            data_d[i] = src_data[i];
        data_d[LO +: CHUNK] = slice[CHUNK-1:0];
        for (int i = 0; i < UP - CHUNK; i++) begin
            data_d[LO+CHUNK+i] = src_data[LO+CHUNK+i];
            data_d[LO+UP+i]    = src_data[LO+UP+CHUNK+i];
        end
    end

    generate
        if (FLAG_W == 2) begin : g_last
            logic carry_msb;
            // Carry into a bit is recoverable from its sum and operand bits.
            assign carry_msb = slice[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];
            assign flags_d   = {carry_msb, slice[CHUNK]};
        end else begin : g_mid
            assign flags_d = slice[CHUNK];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
            flags <= '0;
        end else if (ready) begin
            valid <= src_valid;
            if (src_valid) begin
                data  <= data_d;
                flags <= flags_d;
            end
        end
    end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder with valid/ready handshake; one register stage per
// CHUNK-bit slice, combinational ready chain from io_out_ready back to io_in_ready.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [WIDTH-1:0] io_in_lhs,
    input  logic [WIDTH-1:0] io_in_rhs,
    input  logic             io_in_cin,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [WIDTH-1:0] io_out_sum,
    output logic             io_out_cout,
    output logic             io_out_ovf
);

    localparam int STAGES = stages_of(WIDTH, CHUNK);

    generate
        if (!params_ok(WIDTH, CHUNK)) begin : g_bad_params
            $error("pipelined_adder: WIDTH must be a positive multiple of CHUNK, CHUNK >= 1");
        end
    endgenerate

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int IN_W   = 2 * WIDTH - CHUNK * k;
        localparam int OUT_W  = stage_out_w(WIDTH, CHUNK, k);
        localparam int FLAG_W = stage_flag_w(WIDTH, CHUNK, k);

        logic              src_valid;
        logic [IN_W-1:0]   src_data;
        logic              src_carry;
        logic              dst_ready;
        logic              ready;
        logic              valid;
        logic [OUT_W-1:0]  data;
        logic [FLAG_W-1:0] flags;

        if (k == 0) begin : g_head
            assign src_valid = io_in_valid;
            assign src_data  = {io_in_rhs, io_in_lhs};
            assign src_carry = io_in_cin;
        end else begin : g_link
            assign src_valid = g_stg[k-1].valid;
            assign src_data  = g_stg[k-1].data;
            assign src_carry = g_stg[k-1].flags[0];
        end

        if (k == STAGES - 1) begin : g_tail
            assign dst_ready = io_out_ready;
        end else begin : g_chain
            assign dst_ready = g_stg[k+1].ready;
        end

        adder_stage #(
            .WIDTH (WIDTH),
            .CHUNK (CHUNK),
            .IDX   (k)
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .src_valid (src_valid),
            .src_data  (src_data),
            .src_carry (src_carry),
            .dst_ready (dst_ready),
            .ready     (ready),
            .valid     (valid),
            .data      (data),
            .flags     (flags)
        );
    end

    assign io_in_ready  = g_stg[0].ready;
    assign io_out_valid = g_stg[STAGES-1].valid;
    assign io_out_sum   = g_stg[STAGES-1].data;
    assign io_out_cout  = g_stg[STAGES-1].flags[0];
    assign io_out_ovf   = g_stg[STAGES-1].flags[1] ^ g_stg[STAGES-1].flags[0];

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and random checks of pipelined_adder in three geometries (8/2, 7/7, 16/4)
// sharing one stimulus stream.
module tb_pipelined_adder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        cin = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] lhs = '0;
    logic [15:0] rhs = '0;

    logic        in_ready_8, out_valid_8, cout_8, ovf_8;
    logic [7:0]  sum_8;
    logic        in_ready_7, out_valid_7, cout_7, ovf_7;
    logic [6:0]  sum_7;
    logic        in_ready_16, out_valid_16, cout_16, ovf_16;
    logic [15:0] sum_16;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(8), .CHUNK(2)) dut8 (
        .clk(clk), .reset(reset),
        .io_in_valid(in_valid), .io_in_ready(in_ready_8),
        .io_in_lhs(lhs[7:0]), .io_in_rhs(rhs[7:0]), .io_in_cin(cin),
        .io_out_valid(out_valid_8), .io_out_ready(out_ready),
        .io_out_sum(sum_8), .io_out_cout(cout_8), .io_out_ovf(ovf_8)
    );

    pipelined_adder #(.WIDTH(7), .CHUNK(7)) dut7 (
        .clk(clk), .reset(reset),
        .io_in_valid(in_valid), .io_in_ready(in_ready_7),
        .io_in_lhs(lhs[6:0]), .io_in_rhs(rhs[6:0]), .io_in_cin(cin),
        .io_out_valid(out_valid_7), .io_out_ready(out_ready),
        .io_out_sum(sum_7), .io_out_cout(cout_7), .io_out_ovf(ovf_7)
    );

    pipelined_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk(clk), .reset(reset),
        .io_in_valid(in_valid), .io_in_ready(in_ready_16),
        .io_in_lhs(lhs), .io_in_rhs(rhs), .io_in_cin(cin),
        .io_out_valid(out_valid_16), .io_out_ready(out_ready),
        .io_out_sum(sum_16), .io_out_cout(cout_16), .io_out_ovf(ovf_16)
    );

    // Returns {ovf, cout, sum zero-extended to 16 bits}; overflow from operand/result signs.
    function automatic logic [17:0] ref_add(int w, logic [15:0] a, logic [15:0] b, logic c);
        logic [16:0] mask17;
        logic [15:0] mask, aa, bb, s;
        logic [16:0] full;
        logic        co, ov;
        mask17 = (17'h1 << w) - 17'h1;
        mask   = mask17[15:0];
        aa     = a & mask;
        bb     = b & mask;
        full   = {1'b0, aa} + {1'b0, bb} + {16'h0, c};
        s      = full[15:0] & mask;
        co     = full[w];
        ov     = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
        return {ov, co, s};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if ({in_ready_8, out_valid_8, sum_8, cout_8, ovf_8} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL reset_idle cycle %0d: got ready=%b valid=%b sum=%h cout=%b ovf=%b, want ready=1 valid=0 sum=00 cout=0 ovf=0",
                         i, in_ready_8, out_valid_8, sum_8, cout_8, ovf_8);
            end
        end
    endtask

    task automatic test_single(input string name, input logic [7:0] a, input logic [7:0] b,
                               input logic c, input logic [7:0] exp_sum, input logic exp_cout,
                               input logic exp_ovf);
        @(negedge clk);
        in_valid = 1'b1;
        lhs = {8'h00, a};
        rhs = {8'h00, b};
        cin = c;
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready_8 !== 1'b1) begin
            bad++;
            $display("FAIL %s_in_ready: got %b want 1", name, in_ready_8);
        end
        @(negedge clk);
        in_valid = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            if (n > 1) @(negedge clk);
            total++;
            if (out_valid_8 !== (n == 4)) begin
                bad++;
                $display("FAIL %s_latency cycle %0d: got valid=%b want %b", name, n, out_valid_8, (n == 4));
            end
        end
        total++;
        if ({sum_8, cout_8, ovf_8} !== {exp_sum, exp_cout, exp_ovf}) begin
            bad++;
            $display("FAIL %s_result: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                     name, sum_8, cout_8, ovf_8, exp_sum, exp_cout, exp_ovf);
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] q8[$];
        logic [17:0] q7[$];
        logic [17:0] q16[$];
        logic [17:0] e;
        out_ready = 1'b1;
        for (int i = 0; i < 110; i++) begin
            @(negedge clk);
            total++;
            if (out_valid_8 !== (i >= 4 && i < 104)) begin
                bad++;
                $display("FAIL stream8_valid cycle %0d: got %b want %b", i, out_valid_8, (i >= 4 && i < 104));
            end
            if (out_valid_8 && q8.size() > 0) begin
                e = q8.pop_front();
                total++;
                if ({ovf_8, cout_8, 8'h00, sum_8} !== e) begin
                    bad++;
                    $display("FAIL stream8_data cycle %0d: got %h want %h", i, {ovf_8, cout_8, 8'h00, sum_8}, e);
                end
            end
            total++;
            if (out_valid_7 !== (i >= 1 && i < 101)) begin
                bad++;
                $display("FAIL stream7_valid cycle %0d: got %b want %b", i, out_valid_7, (i >= 1 && i < 101));
            end
            if (out_valid_7 && q7.size() > 0) begin
                e = q7.pop_front();
                total++;
                if ({ovf_7, cout_7, 9'h000, sum_7} !== e) begin
                    bad++;
                    $display("FAIL stream7_data cycle %0d: got %h want %h", i, {ovf_7, cout_7, 9'h000, sum_7}, e);
                end
            end
            total++;
            if (out_valid_16 !== (i >= 4 && i < 104)) begin
                bad++;
                $display("FAIL stream16_valid cycle %0d: got %b want %b", i, out_valid_16, (i >= 4 && i < 104));
            end
            if (out_valid_16 && q16.size() > 0) begin
                e = q16.pop_front();
                total++;
                if ({ovf_16, cout_16, sum_16} !== e) begin
                    bad++;
                    $display("FAIL stream16_data cycle %0d: got %h want %h", i, {ovf_16, cout_16, sum_16}, e);
                end
            end
            if (i < 100) begin
                lhs = 16'($urandom());
                rhs = 16'($urandom());
                cin = 1'($urandom());
                in_valid = 1'b1;
                #1;
                total++;
                if ({in_ready_8, in_ready_7, in_ready_16} !== 3'b111) begin
                    bad++;
                    $display("FAIL stream_in_ready cycle %0d: got %b want 111", i,
                             {in_ready_8, in_ready_7, in_ready_16});
                end
                q8.push_back(ref_add(8, lhs, rhs, cin));
                q7.push_back(ref_add(7, lhs, rhs, cin));
                q16.push_back(ref_add(16, lhs, rhs, cin));
            end else begin
                in_valid = 1'b0;
            end
        end
        total++;
        if ({q8.size(), q7.size(), q16.size()} !== {32'd0, 32'd0, 32'd0}) begin
            bad++;
            $display("FAIL stream_leftover: got q8=%0d q7=%0d q16=%0d want 0 0 0", q8.size(), q7.size(), q16.size());
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] va[5];
        logic [7:0] vb[5];
        logic       vc[5];
        logic [9:0] ve[5];
        int         idx;
        // ve = {ovf, cout, sum}
        va = '{8'h01, 8'h10, 8'hF0, 8'h40, 8'h55};
        vb = '{8'h02, 8'h20, 8'h20, 8'h40, 8'h55};
        vc = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b0};
        ve = '{10'h003, 10'h031, 10'h110, 10'h280, 10'h2AA};
        idx = 0;
        @(negedge clk);
        out_ready = 1'b0;
        for (int n = 0; n < 8; n++) begin
            if (n > 0) @(negedge clk);
            in_valid = 1'b1;
            lhs = {8'h00, va[idx]};
            rhs = {8'h00, vb[idx]};
            cin = vc[idx];
            #1;
            total++;
            if (in_ready_8 !== (n < 4)) begin
                bad++;
                $display("FAIL bp_in_ready offer %0d: got %b want %b", n, in_ready_8, (n < 4));
            end
            if (n >= 4) begin
                total++;
                if ({out_valid_8, ovf_8, cout_8, sum_8} !== {1'b1, ve[0]}) begin
                    bad++;
                    $display("FAIL bp_hold offer %0d: got valid=%b flags/sum=%h want valid=1 flags/sum=%h",
                             n, out_valid_8, {ovf_8, cout_8, sum_8}, ve[0]);
                end
            end
            if (in_ready_8 && idx < 4) idx++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            if (j > 0) @(negedge clk);
            total++;
            if (out_valid_8 !== (j < 4)) begin
                bad++;
                $display("FAIL bp_drain_valid step %0d: got %b want %b", j, out_valid_8, (j < 4));
            end else if (j < 4) begin
                total++;
                if ({ovf_8, cout_8, sum_8} !== ve[j]) begin
                    bad++;
                    $display("FAIL bp_drain_data step %0d: got %h want %h", j, {ovf_8, cout_8, sum_8}, ve[j]);
                end
            end
        end
    endtask

    task automatic test_reset_inflight();
        out_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            in_valid = 1'b1;
            lhs = 16'h0011 + 16'(n);
            rhs = 16'h0022;
            cin = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({out_valid_8, in_ready_8} !== 2'b01) begin
            bad++;
            $display("FAIL reset_inflight: got valid=%b ready=%b want valid=0 ready=1", out_valid_8, in_ready_8);
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (out_valid_8 !== 1'b0) begin
                bad++;
                $display("FAIL reset_flush cycle %0d: got valid=%b want 0", i, out_valid_8);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single("ovf_pos", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        test_single("wrap",    8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        test_single("all_one", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
        test_single("ovf_neg", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        test_back_to_back();
        test_backpressure();
        test_reset_inflight();
        test_single("post_rst", 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined successor to the single-cycle ripple adder. Adds two WIDTH-bit operands plus carry-in by splitting the carry chain into CHUNK-bit slices, with one register stage per slice. Produces sum, carry-out and a signed-overflow flag. Sits between valid/ready producers and consumers in the datapath, with full backpressure and a throughput of one operation per cycle.

## Interface
- WIDTH, 8: operand and sum width; must be a multiple of CHUNK.
- CHUNK, 2: bits resolved per stage; STAGES = WIDTH/CHUNK (≥1).
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- io_in_valid  in  1  operand transfer offered.
- io_in_ready  out  1  pipeline can accept a transfer this cycle.
- io_in_lhs  in  WIDTH  left operand (unsigned or two's complement).
- io_in_rhs  in  WIDTH  right operand.
- io_in_cin  in  1  carry-in.
- io_out_valid  out  1  result available.
- io_out_ready  in  1  consumer accepts result.
- io_out_sum  out  WIDTH  (lhs + rhs + cin) mod 2^WIDTH.
- io_out_cout  out  1  carry out of bit WIDTH-1.
- io_out_ovf  out  1  signed overflow: carry into bit WIDTH-1 XOR io_out_cout.

## Operation
- Stage k (0..STAGES-1) holds a valid bit v[k], the completed sum bits [CHUNK*(k+1)-1:0], the pending upper operand bits, and the carry leaving slice k.
- Stage 0 captures io_in_* on handshake (io_in_valid && io_in_ready) and resolves slice 0 using io_in_cin.
- Stage k>0 resolves slice k from the operand bits it receives and the registered carry of stage k-1.
- The last stage also registers the carry into bit WIDTH-1 so that io_out_ovf is computed from registered values.
- Advance rule: stage k loads when v[k-1] && (!v[k] || moves[k]). Stage k empties when its contents move on and nothing replaces them. The output moves on io_out_valid && io_out_ready.
- io_in_ready = !v[0] || stage 0 advancing this cycle. This is a combinational ready chain from io_out_ready; no skid buffer is used.
- io_out_valid = v[STAGES-1]. io_out_sum, io_out_cout and io_out_ovf come directly from last-stage registers and hold stable while io_out_valid && !io_out_ready.
- Arithmetic per slice is CHUNK+1 bits wide, with zero-extended operands and carry. There is no sign extension: signedness affects only the interpretation of io_out_ovf.
- When STAGES=1, the block degenerates to a single registered adder with the same handshake.

## Timing
- Reset: all v[k]=0 and all data registers 0. In the cycle after reset deasserts: io_out_valid=0, io_out_sum=0, io_out_cout=0, io_out_ovf=0, io_in_ready=1.
- Reset asserted mid-operation discards every in-flight transfer at the next edge. No partial result is ever presented.
- Latency: a transfer accepted in cycle t presents io_out_valid in cycle t+STAGES when there is no backpressure.
- Throughput: one transfer per cycle while io_out_ready=1.
- Full pipeline with io_out_ready=0:
  - io_in_ready=0.
  - No stage changes its contents.
  - Ordering is preserved, and no transfer is dropped or duplicated.
- Full pipeline with io_out_ready=1 and io_in_valid=1 in the same cycle: output retires and input is accepted in that cycle, keeping occupancy STAGES.
- Bubbles (io_in_valid=0) propagate as v=0 and collapse under backpressure. Stages behind an empty stage keep advancing.

## Structure
- Shared package adder_pkg holds:
  - the STAGES derivation;
  - a parameter legality check (WIDTH % CHUNK == 0, CHUNK ≥ 1), which fails elaboration when violated.
- One sub-module, adder_stage. It is parametrised by CHUNK, slice index and WIDTH, and contains:
  - its valid register, data registers, slice adder and load logic.
- The top instantiates STAGES copies and wires the ready chain.

## Test plan
- Reset, then idle: io_in_ready=1, io_out_valid=0, and all outputs 0 for 10 cycles.
- WIDTH=8, CHUNK=2, lhs=0x7F, rhs=0x01, cin=0: after exactly 4 cycles, sum=0x80, cout=0, ovf=1.
- lhs=0xFF, rhs=0x01, cin=0 gives sum=0x00, cout=1, ovf=0. lhs=0xFF, rhs=0xFF, cin=1 gives sum=0xFF, cout=1, ovf=0.
- Back-to-back stream of 100 random operands with io_out_ready=1: one result per cycle, in order, each matching a reference model.
- Fill the pipeline with io_out_ready=0:
  - io_in_ready drops to 0 after 4 accepts.
  - Outputs are held stable.
  - Release io_out_ready: all 4 results appear in order, with no loss or duplication.
- Assert reset with 3 transfers in flight: io_out_valid=0 the cycle after, and a new transfer then completes normally. Repeat the random test with WIDTH=7, CHUNK=7 and with WIDTH=16, CHUNK=4.
